// File: rtl/sin_meas_pkg.sv
// Shared types and default constants for the sine-tone measurement blocks.
package sin_meas_pkg;

   typedef enum logic [1:0] {
      ST_UNKNOWN = 2'd0,
      ST_LOW     = 2'd1,
      ST_HIGH    = 2'd2
   } cmp_state_e;

   localparam int unsigned CLK_HZ   = 12000000;
   localparam int unsigned ADC_W    = 10;
   localparam int unsigned MIDSCALE = 512;
   localparam int unsigned FREQ_W   = 16;

endpackage

// File: rtl/sin_schmitt_edge.sv
// Hysteresis comparator on unsigned sine samples; emits a registered one-cycle
// pulse on each low-to-high crossing.
module sin_schmitt_edge #(
   parameter int unsigned ADC_W    = sin_meas_pkg::ADC_W,
   parameter int unsigned MIDSCALE = sin_meas_pkg::MIDSCALE,
   parameter int unsigned HYST     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_valid,
   input  logic [ADC_W-1:0] sample,
   output logic             rise
);
   import sin_meas_pkg::*;

   localparam logic [ADC_W-1:0] THR_LO = ADC_W'(MIDSCALE - HYST);
   localparam logic [ADC_W-1:0] THR_HI = ADC_W'(MIDSCALE + HYST);

   cmp_state_e state_q, state_d;
   logic       rise_q, rise_d;

   always_comb begin
      state_d = state_q;
      rise_d  = 1'b0;
      if (sample_valid) begin
         case (state_q)
            ST_UNKNOWN: begin
               // Initial classification only; never produces an edge.
               if (sample <= THR_LO) begin
                  state_d = ST_LOW;
               end else if (sample >= THR_HI) begin
                  state_d = ST_HIGH;
               end
            end
            ST_LOW: begin
               if (sample >= THR_HI) begin
                  state_d = ST_HIGH;
                  rise_d  = 1'b1;
               end
            end
            ST_HIGH: begin
               if (sample <= THR_LO) begin
                  state_d = ST_LOW;
               end
            end
            default: state_d = ST_UNKNOWN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_UNKNOWN;
         rise_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rise_q  <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/sin_freq_meter.sv
// Gated frequency and edge-to-edge period meter for sampled sine tones.
// Define SIN_FREQ_METER_AVG_EN to report the mean of every 4 periods instead.
module sin_freq_meter #(
   parameter int unsigned GATE_CYCLES = sin_meas_pkg::CLK_HZ,
   parameter int unsigned MIDSCALE    = sin_meas_pkg::MIDSCALE,
   parameter int unsigned HYST        = 16,
   parameter int unsigned PERIOD_W    = 24
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             sample_valid,
   input  logic [sin_meas_pkg::ADC_W-1:0]   sample,
   output logic [sin_meas_pkg::FREQ_W-1:0]  freq_hz,
   output logic [PERIOD_W-1:0]              period_clks,
   output logic                             meas_valid,
   output logic                             period_valid,
   output logic                             signal_lost
);
   import sin_meas_pkg::*;

   localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0]   GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
   localparam logic [FREQ_W-1:0]   FREQ_MAX   = '1;

   logic rise;

   sin_schmitt_edge #(
      .ADC_W    (ADC_W),
      .MIDSCALE (MIDSCALE),
      .HYST     (HYST)
   ) u_edge (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample       (sample),
      .rise         (rise)
   );

   logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
   logic [FREQ_W-1:0]   edge_cnt_q, edge_cnt_d, edge_next;
   logic [FREQ_W-1:0]   freq_q, freq_d;
   logic                meas_valid_q, meas_valid_d;
   logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d, period_meas;
   logic [PERIOD_W-1:0] period_clks_q, period_clks_d;
   logic                period_valid_q, period_valid_d;
   logic                armed_q, armed_d;
   logic                lost_q, lost_d;
`ifdef SIN_FREQ_METER_AVG_EN
   logic [PERIOD_W+1:0] acc_q, acc_d, acc_sum;
   logic [1:0]          avg_cnt_q, avg_cnt_d;
   logic                avg_sat_q, avg_sat_d;
`endif

   always_comb begin
      edge_next   = (edge_cnt_q == FREQ_MAX) ? FREQ_MAX : edge_cnt_q + FREQ_W'(rise);
      period_meas = (period_cnt_q == PERIOD_MAX) ? PERIOD_MAX
                                                 : period_cnt_q + PERIOD_W'(1);

      gate_cnt_d     = gate_cnt_q + GATE_W'(1);
      edge_cnt_d     = edge_next;
      freq_d         = freq_q;
      meas_valid_d   = 1'b0;
      period_cnt_d   = period_meas;
      period_clks_d  = period_clks_q;
      period_valid_d = 1'b0;
      armed_d        = armed_q;
`ifdef SIN_FREQ_METER_AVG_EN
      acc_d     = acc_q;
      avg_cnt_d = avg_cnt_q;
      avg_sat_d = avg_sat_q;
      acc_sum   = acc_q + {2'b00, period_meas};
`endif

      // A rise on the wrap cycle is already folded into edge_next.
      if (gate_cnt_q == GATE_LAST) begin
         gate_cnt_d   = '0;
         freq_d       = edge_next;
         edge_cnt_d   = '0;
         meas_valid_d = 1'b1;
      end

      if (rise) begin
         period_cnt_d = '0;
         armed_d      = 1'b1;
         if (armed_q) begin
`ifdef SIN_FREQ_METER_AVG_EN
            avg_cnt_d = avg_cnt_q + 2'd1;
            if (avg_cnt_q == 2'd3) begin
               period_clks_d  = (avg_sat_q || period_meas == PERIOD_MAX) ? PERIOD_MAX
                                                                         : acc_sum[PERIOD_W+1:2];
               period_valid_d = 1'b1;
               acc_d          = '0;
               avg_sat_d      = 1'b0;
            end else begin
               acc_d     = acc_sum;
               avg_sat_d = avg_sat_q | (period_meas == PERIOD_MAX);
            end
`else
            period_clks_d  = period_meas;
            period_valid_d = 1'b1;
`endif
         end
      end

      // A rise zeroes the counter, so this also clears the flag on the next crossing.
      lost_d = (period_cnt_d == PERIOD_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gate_cnt_q     <= '0;
         edge_cnt_q     <= '0;
         freq_q         <= '0;
         meas_valid_q   <= 1'b0;
         period_cnt_q   <= '0;
         period_clks_q  <= '0;
         period_valid_q <= 1'b0;
         armed_q        <= 1'b0;
         lost_q         <= 1'b0;
`ifdef SIN_FREQ_METER_AVG_EN
         acc_q          <= '0;
         avg_cnt_q      <= '0;
         avg_sat_q      <= 1'b0;
`endif
      end else begin
         gate_cnt_q     <= gate_cnt_d;
         edge_cnt_q     <= edge_cnt_d;
         freq_q         <= freq_d;
         meas_valid_q   <= meas_valid_d;
         period_cnt_q   <= period_cnt_d;
         period_clks_q  <= period_clks_d;
         period_valid_q <= period_valid_d;
         armed_q        <= armed_d;
         lost_q         <= lost_d;
`ifdef SIN_FREQ_METER_AVG_EN
         acc_q          <= acc_d;
         avg_cnt_q      <= avg_cnt_d;
         avg_sat_q      <= avg_sat_d;
`endif
      end
   end

   assign freq_hz      = freq_q;
   assign period_clks  = period_clks_q;
   assign meas_valid   = meas_valid_q;
   assign period_valid = period_valid_q;
   assign signal_lost  = lost_q;

endmodule

// File: tb/tb_sin_freq_meter.sv
// Scoreboard bench for sin_freq_meter: directed sample streams, expected
// measurements queued up front and checked by a monitor on every valid pulse.
module tb_sin_freq_meter;

   localparam int unsigned GATE = 1000;
   localparam int unsigned PW   = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sample_valid = 1'b1;
   logic [9:0]    sample = '0;
   logic [15:0]   freq_hz;
   logic [PW-1:0] period_clks;
   logic          meas_valid;
   logic          period_valid;
   logic          signal_lost;

   sin_freq_meter #(
      .GATE_CYCLES (GATE),
      .MIDSCALE    (512),
      .HYST        (16),
      .PERIOD_W    (PW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample       (sample),
      .freq_hz      (freq_hz),
      .period_clks  (period_clks),
      .meas_valid   (meas_valid),
      .period_valid (period_valid),
      .signal_lost  (signal_lost)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int exp_freq[$];
   int exp_period[$];   // -1 means the pulse is expected but its value is not checked
   int edge_idx   = 0;
   int first_meas = -1;
   int ef;
   int ep;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per valid pulse.
   always @(negedge clk) begin
      if (meas_valid) begin
         if (exp_freq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL meas_unexpected: freq_hz=%0d with no expected value (t=%0t)",
                     freq_hz, $time);
         end else begin
            ef = exp_freq.pop_front();
            check("freq_hz", longint'(freq_hz), longint'(ef));
         end
      end
      if (period_valid) begin
         if (exp_period.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL period_unexpected: period_clks=%0d with no expected value (t=%0t)",
                     period_clks, $time);
         end else begin
            ep = exp_period.pop_front();
            if (ep >= 0) check("period_clks", longint'(period_clks), longint'(ep));
         end
      end
   end

   task automatic run(input int n, input logic [9:0] v, input logic vld = 1'b1);
      for (int i = 0; i < n; i++) begin
         sample       = v;
         sample_valid = vld;
         @(posedge clk);
         #1;
         if (meas_valid && first_meas < 0) first_meas = edge_idx;
         edge_idx++;
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      sample       = '0;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      edge_idx   = 0;
      first_meas = -1;
   endtask

   task automatic push_freq(input int v, input int n);
      for (int i = 0; i < n; i++) exp_freq.push_back(v);
   endtask

   task automatic push_period(input int v, input int n);
      for (int i = 0; i < n; i++) exp_period.push_back(v);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_freq_hz"}, longint'(freq_hz), 0);
      check({tag, "_period_clks"}, longint'(period_clks), 0);
      check({tag, "_meas_valid"}, longint'(meas_valid), 0);
      check({tag, "_period_valid"}, longint'(period_valid), 0);
      check({tag, "_signal_lost"}, longint'(signal_lost), 0);
   endtask

   initial begin
      #(10 * 100000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Square wave, period 100: 10 rises per gate; first rise only arms.
      do_reset();
      check_outputs_zero("reset");
      push_freq(10, 3);
      push_period(100, 29);
      for (int p = 0; p < 30; p++) begin
         run(50, 10'd0);
         run(50, 10'd1023);
      end

      // Tenth rise lands exactly on the gate wrap; next gate sees none.
      do_reset();
      push_freq(10, 1);
      push_freq(0, 1);
      push_period(100, 9);
      run(98, 10'd0);
      for (int p = 0; p < 10; p++) begin
         run(50, 10'd1023);
         run(50, 10'd0);
      end
      run(902, 10'd0);

      // In-band dither never toggles; invalid samples are ignored; 600 rises once.
      do_reset();
      push_freq(0, 2);
      push_freq(2, 1);
      push_period(95, 1);
      run(10, 10'd0);
      for (int i = 0; i < 1000; i++) begin
         run(1, 10'd505);
         run(1, 10'd519);
      end
      run(5, 10'd1023, 1'b0);
      run(45, 10'd600);
      run(50, 10'd0);
      run(50, 10'd1023);
      run(840, 10'd0);

      // Lock, then flat midscale until the 12-bit period counter saturates.
      do_reset();
      push_freq(3, 1);
      push_freq(0, 3);
      push_freq(2, 1);
      push_period(100, 2);
      push_period(-1, 1);
      push_period(100, 1);
      for (int p = 0; p < 3; p++) begin
         run(50, 10'd0);
         run(50, 10'd1023);
      end
      run(4045, 10'd512);
      check("lost_before_sat", longint'(signal_lost), 0);
      run(1, 10'd512);
      check("lost_at_4094", longint'(signal_lost), 0);
      run(1, 10'd512);
      check("lost_at_4095", longint'(signal_lost), 1);
      check("period_held_while_lost", longint'(period_clks), 100);
      run(53, 10'd512);
      run(50, 10'd0);
      run(1, 10'd1023);
      check("lost_until_rise", longint'(signal_lost), 1);
      run(49, 10'd1023);
      check("lost_cleared", longint'(signal_lost), 0);
      run(50, 10'd0);
      run(450, 10'd1023);

      // Mid-gate reset: leave comparator LOW, then reset for one cycle.
      do_reset();
      push_freq(10, 1);
      push_period(100, 14);
      for (int p = 0; p < 15; p++) begin
         run(50, 10'd0);
         run(50, 10'd1023);
      end
      run(30, 10'd0);
      check("pre_reset_freq", longint'(freq_hz), 10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_outputs_zero("midreset");
      rst        = 1'b0;
      edge_idx   = 0;
      first_meas = -1;
      push_freq(2, 1);
      push_period(100, 1);
      run(30, 10'd1023);
      run(50, 10'd0);
      run(50, 10'd1023);
      run(50, 10'd0);
      run(821, 10'd1023);
      check("first_meas_edge", longint'(first_meas), longint'(GATE - 1));

      @(negedge clk);
      #1;
      check("freq_queue_left", longint'(exp_freq.size()), 0);
      check("period_queue_left", longint'(exp_period.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
